// File: rtl/ntt_sdf_ctrl.sv
// Sequencer for one SDF NTT stage: counts coefficients and drives the delay line and butterfly controls.
// Latency: control strobes are combinational with the accepted sample; tw_idx/blk_cnt/pulses are registered.
// Backpressure: accepts every valid sample in FILL/BFLY; in_ready drops only while a flush drains the line.
module ntt_sdf_ctrl #(
  parameter int LEN   = 32,
  parameter int BLK_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    flush,
  output logic                    in_ready,
  output logic                    d_en,
  output logic                    bf_sel,
  output logic                    zero_in,
  output logic                    out_valid,
  output logic [$clog2(LEN)-1:0]  tw_idx,
  output logic [BLK_W-1:0]        blk_cnt,
  output logic                    blk_done,
  output logic                    flush_done
);

  localparam int CW = $clog2(LEN);
  localparam logic [CW-1:0] CNT_MAX = CW'(LEN - 1);

  localparam logic [1:0] ST_FILL  = 2'd0;
  localparam logic [1:0] ST_BFLY  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          primed;
  logic          adv;
  logic          cnt_last;

  assign cnt_last = (cnt == CNT_MAX);
  assign tw_idx   = cnt;

  // Decode the per-cycle controls from registered state and the live in_valid.
  always_comb begin
    adv       = 1'b0;
    in_ready  = 1'b0;
    bf_sel    = 1'b0;
    zero_in   = 1'b0;
    out_valid = 1'b0;
    if (!rst) begin
      case (state)
        ST_FILL: begin
          adv       = in_valid;
          in_ready  = 1'b1;
          // Delay output is only meaningful once a previous block left lower results in it.
          out_valid = in_valid && primed;
        end
        ST_BFLY: begin
          adv       = in_valid;
          in_ready  = 1'b1;
          bf_sel    = 1'b1;
          out_valid = in_valid;
        end
        ST_FLUSH: begin
          adv       = 1'b1;
          zero_in   = 1'b1;
          out_valid = 1'b1;
        end
        default: begin
          adv = 1'b0;
        end
      endcase
    end
  end

  assign d_en = adv;

  // Advance the phase counter and state machine; pulses default low every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_FILL;
      cnt        <= '0;
      primed     <= 1'b0;
      blk_cnt    <= '0;
      blk_done   <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      blk_done   <= 1'b0;
      flush_done <= 1'b0;
      case (state)
        ST_FILL: begin
          if (in_valid) begin
            if (cnt_last) begin
              cnt   <= '0;
              state <= ST_BFLY;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end else if (flush && cnt == '0 && primed) begin
            // Only drain at a block boundary and only if there is something to drain.
            state <= ST_FLUSH;
          end
        end
        ST_BFLY: begin
          if (in_valid) begin
            if (cnt_last) begin
              cnt      <= '0;
              state    <= ST_FILL;
              primed   <= 1'b1;
              blk_cnt  <= blk_cnt + BLK_W'(1);
              blk_done <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        ST_FLUSH: begin
          if (cnt_last) begin
            cnt        <= '0;
            state      <= ST_FILL;
            primed     <= 1'b0;
            flush_done <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= ST_FILL;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_sdf_ctrl.sv
// Directed bench for ntt_sdf_ctrl with LEN=4 and a 2-bit block counter (so wrap is reachable).
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit after that.
// Control vector order in checks: {in_ready, d_en, bf_sel, zero_in, out_valid}.
module tb_ntt_sdf_ctrl;

  localparam int LEN   = 4;
  localparam int BLK_W = 2;

  localparam logic [4:0] C_FILL   = 5'b11000;
  localparam logic [4:0] C_FILLP  = 5'b11001;
  localparam logic [4:0] C_BFLY   = 5'b11101;
  localparam logic [4:0] C_STALLF = 5'b10000;
  localparam logic [4:0] C_STALLB = 5'b10100;
  localparam logic [4:0] C_FLUSH  = 5'b01011;
  localparam logic [4:0] C_OFF    = 5'b00000;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             flush;
  logic             in_ready;
  logic             d_en;
  logic             bf_sel;
  logic             zero_in;
  logic             out_valid;
  logic [1:0]       tw_idx;
  logic [BLK_W-1:0] blk_cnt;
  logic             blk_done;
  logic             flush_done;

  int tests = 0;
  int fails = 0;

  ntt_sdf_ctrl #(.LEN(LEN), .BLK_W(BLK_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .flush      (flush),
    .in_ready   (in_ready),
    .d_en       (d_en),
    .bf_sel     (bf_sel),
    .zero_in    (zero_in),
    .out_valid  (out_valid),
    .tw_idx     (tw_idx),
    .blk_cnt    (blk_cnt),
    .blk_done   (blk_done),
    .flush_done (flush_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle, check the combinational controls and tw_idx, then cross the edge.
  task automatic step(input string tag, input logic v, input logic f,
                      input logic [4:0] ctl, input int tw);
    in_valid = v;
    flush    = f;
    #1;
    chk($sformatf("%s.ctl", tag), 32'({in_ready, d_en, bf_sel, zero_in, out_valid}), 32'(ctl));
    chk($sformatf("%s.tw", tag), 32'(tw_idx), 32'(tw));
    tick();
  endtask

  task automatic chk_regs(input string tag, input int bc, input logic bd, input logic fd);
    chk($sformatf("%s.blk_cnt", tag), 32'(blk_cnt), 32'(bc));
    chk($sformatf("%s.blk_done", tag), 32'(blk_done), 32'(bd));
    chk($sformatf("%s.flush_done", tag), 32'(flush_done), 32'(fd));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; flush = 1'b1;
    tick();
    tick();
    // Strobes held low during reset even with in_valid/flush asserted.
    chk("rst.ctl", 32'({in_ready, d_en, bf_sel, zero_in, out_valid}), 32'(C_OFF));
    chk("rst.tw", 32'(tw_idx), 32'd0);
    chk_regs("rst", 0, 1'b0, 1'b0);
    in_valid = 1'b0; flush = 1'b0; rst = 1'b0;
    tick();

    // Continuous stream: fill, butterfly, primed fill, butterfly.
    for (int i = 0; i < 16; i++) begin
      step($sformatf("cont%0d", i + 1), 1'b1, 1'b0,
           (i < 4) ? C_FILL : (((i / 4) % 2) == 1 ? C_BFLY : C_FILLP), i % 4);
      chk($sformatf("cont%0d.blk_done", i + 1), 32'(blk_done), 32'(i == 7 || i == 15));
    end
    chk("cont.blk_cnt", 32'(blk_cnt), 32'd2);
    step("cont.idle", 1'b0, 1'b0, C_STALLF, 0);
    chk("cont.idle.blk_done", 32'(blk_done), 32'd0);

    // Gaps after reset: alternate valid/idle; d_en follows in_valid and tw_idx holds.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) begin
        step($sformatf("gap%0d", i), 1'b1, 1'b0, (i / 2 < 4) ? C_FILL : C_BFLY, (i / 2) % 4);
      end else begin
        step($sformatf("gap%0d", i), 1'b0, 1'b0,
             ((i / 2 + 1) >= 4 && (i / 2 + 1) < 8) ? C_STALLB : C_STALLF, (i / 2 + 1) % 4);
      end
      chk($sformatf("gap%0d.blk_done", i), 32'(blk_done), 32'(i == 14));
    end
    chk("gap.blk_cnt", 32'(blk_cnt), 32'd1);

    // Flush from a primed block boundary; in_valid during flush is ignored.
    step("fl.req", 1'b0, 1'b1, C_STALLF, 0);
    for (int i = 0; i < 4; i++) begin
      step($sformatf("fl%0d", i), (i == 1), 1'b0, C_FLUSH, i);
      chk($sformatf("fl%0d.flush_done", i), 32'(flush_done), 32'(i == 3));
    end
    for (int i = 0; i < 8; i++) begin
      step($sformatf("pfl%0d", i), 1'b1, 1'b0, (i < 4) ? C_FILL : C_BFLY, i % 4);
      chk($sformatf("pfl%0d.flush_done", i), 32'(flush_done), 32'd0);
    end
    chk_regs("pfl", 2, 1'b1, 1'b0);

    // Ignored flushes: with a sample at cnt=0, then mid-fill at cnt=2.
    step("ign.v", 1'b1, 1'b1, C_FILLP, 0);
    step("ign.a", 1'b1, 1'b0, C_FILLP, 1);
    step("ign.c2", 1'b0, 1'b1, C_STALLF, 2);
    step("ign.after", 1'b0, 1'b0, C_STALLF, 2);
    step("ign.b", 1'b1, 1'b0, C_FILLP, 2);
    step("ign.c", 1'b1, 1'b0, C_FILLP, 3);
    for (int i = 0; i < 4; i++) step($sformatf("ign.bf%0d", i), 1'b1, 1'b0, C_BFLY, i);
    chk_regs("ign", 3, 1'b1, 1'b0);

    // Reset in the middle of a butterfly phase.
    for (int i = 0; i < 4; i++) step($sformatf("rb.f%0d", i), 1'b1, 1'b0, C_FILLP, i);
    step("rb.b0", 1'b1, 1'b0, C_BFLY, 0);
    step("rb.b1", 1'b1, 1'b0, C_BFLY, 1);
    rst = 1'b1; in_valid = 1'b1;
    #1;
    chk("rb.rst.ctl", 32'({in_ready, d_en, bf_sel, zero_in, out_valid}), 32'(C_OFF));
    tick();
    rst = 1'b0;
    chk("rb.tw", 32'(tw_idx), 32'd0);
    chk_regs("rb", 0, 1'b0, 1'b0);
    // Flush with nothing primed is ignored.
    step("rb.fl", 1'b0, 1'b1, C_STALLF, 0);
    step("rb.fl2", 1'b0, 1'b0, C_STALLF, 0);
    for (int i = 0; i < 8; i++)
      step($sformatf("rb.s%0d", i), 1'b1, 1'b0, (i < 4) ? C_FILL : C_BFLY, i % 4);
    chk_regs("rb.end", 1, 1'b1, 1'b0);

    // Run three more blocks so the 2-bit block counter wraps 1->2->3->0.
    for (int i = 0; i < 24; i++)
      step($sformatf("wr%0d", i), 1'b1, 1'b0, ((i / 4) % 2) == 1 ? C_BFLY : C_FILLP, i % 4);
    chk_regs("wrap", 0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ntt_sdf_ctrl.md
# ntt_sdf_ctrl

Sequencer for one single-path delay-feedback (SDF) NTT stage built around the 12-bit enable-gated delay line `D` of depth `LEN`. It counts incoming coefficients and drives the delay-line enable and the butterfly/bypass select. It also generates the twiddle index and output-valid strobe. On request it flushes the last block's lower butterfly results out of the delay line. One instance sits beside each stage's delay line in the NTT pipeline. It never touches coefficient data itself.

## Interface
- `LEN`, 32: delay-line depth and half-block size. Must be a power of two, at least 2. It must equal the `LEN` of the paired delay line.
- `BLK_W`, 8: width of the block counter.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  a coefficient is presented this cycle.
- `flush`  in  1  request to drain the delay line after the final block.
- `in_ready`  out  1  the stage accepts a coefficient this cycle.
- `d_en`  out  1  enable to the delay line; the line shifts on this edge.
- `bf_sel`  out  1  0 selects bypass/fill (delay input is the new sample, stage output is the delay output); 1 selects butterfly (stage output is the upper result, delay input is the lower result).
- `zero_in`  out  1  force the delay-line input to 0 (flush).
- `out_valid`  out  1  the stage output is a real result this cycle.
- `tw_idx`  out  $clog2(LEN)  twiddle index, equal to the in-phase counter.
- `blk_cnt`  out  BLK_W  number of completed blocks, wrapping modulo 2^BLK_W.
- `blk_done`  out  1  one-cycle pulse; a block of 2·LEN samples has completed.
- `flush_done`  out  1  one-cycle pulse; the flush has completed.

## Operation
- Registered state:
  - `state` ∈ {FILL, BFLY, FLUSH}.
  - `cnt` (0..LEN-1).
  - `primed`: the delay line holds lower results of a previous block.
  - `blk_cnt`, `blk_done`, `flush_done`.
- `adv` = !rst && ((state∈{FILL,BFLY} && in_valid) || state==FLUSH).
- FILL:
  - in_ready=1, bf_sel=0, zero_in=0, out_valid = adv && primed.
  - On adv, cnt increments.
  - When cnt==LEN-1 and adv: cnt←0, state←BFLY.
- BFLY:
  - in_ready=1, bf_sel=1, zero_in=0, out_valid=adv.
  - On adv, cnt increments.
  - When cnt==LEN-1 and adv: cnt←0, state←FILL, primed←1, blk_cnt++, blk_done←1 for the next cycle.
- Entering FLUSH requires all of: flush=1, state==FILL, cnt==0, primed==1, in_valid==0. Then state←FLUSH.
  - If in_valid is also 1, the sample wins and the flush request is ignored that cycle.
  - A flush in any other state, or with cnt≠0 or primed=0, is ignored.
- FLUSH:
  - in_ready=0, d_en=1, bf_sel=0, zero_in=1, out_valid=1 on every cycle. `in_valid` is ignored.
  - cnt increments every cycle.
  - When cnt==LEN-1: cnt←0, state←FILL, primed←0, flush_done←1 for the next cycle.
- `d_en` = adv.
- `tw_idx` = cnt.
- blk_cnt wraps from 2^BLK_W−1 to 0 with no flag.

## Timing
- Combinational outputs:
  - `d_en`, `bf_sel`, `zero_in`, `out_valid` and `in_ready` decode registered state and the current `in_valid`.
  - They are valid in the same cycle as the accepted sample, so the delay line shifts on the same edge that accepts it.
- `tw_idx`, `blk_cnt`, `blk_done` and `flush_done` are registered.
- Reset:
  - Registered values: state=FILL, cnt=0, primed=0, blk_cnt=0, blk_done=0, flush_done=0.
  - While rst=1: in_ready=0, d_en=0, out_valid=0, bf_sel=0, zero_in=0.
- Reset mid-operation: the delay contents are not cleared (the delay line has no reset). primed=0 guarantees stale contents are never marked valid.
- Latency:
  - The first out_valid occurs on accepted sample LEN+1 after reset or after a flush.
  - In steady state, out_valid accompanies every accepted sample.
- Pulse timing:
  - blk_done is high for exactly the one cycle after the edge that accepts sample 2·LEN of a block.
  - flush_done is high for exactly the one cycle after the LEN-th flush shift.
- Stalls: an in_valid=0 cycle in FILL/BFLY freezes cnt, state and the delay line (d_en=0). There is no timeout.

## Test plan
- Fill and butterfly (LEN=4): reset, then 4 samples. Required:
  - d_en=1 ×4, out_valid=0, bf_sel=0.
  - On the next 4 samples: bf_sel=1, out_valid=1, tw_idx=0,1,2,3.
- Continuous stream (LEN=4): 16 back-to-back samples. Required:
  - blk_done pulses the cycle after samples 8 and 16; blk_cnt ends at 2.
  - out_valid high on samples 5–16 (12 cycles), including FILL of block 2 (primed).
- Gaps (LEN=4): in_valid pattern 1,0,1,0,… for 8 samples. Required:
  - d_en mirrors in_valid.
  - tw_idx holds during gaps.
  - BFLY entered only after the 4th accepted sample; blk_done after the 8th.
- Flush (LEN=4): 8 samples, then flush=1 with in_valid=0. Required:
  - 4 cycles with in_ready=0, d_en=1, zero_in=1, out_valid=1; then flush_done pulses.
  - The next 4 samples give out_valid=0.
- Ignored flush (LEN=4): flush at cnt=2 in FILL, and separately flush together with in_valid=1 at cnt=0. Required:
  - state is not FLUSH, zero_in=0, and the sample is accepted normally.
- Reset mid-BFLY (LEN=4): assert rst at cnt=2 of BFLY. Required:
  - Next cycle: state=FILL, cnt=0, blk_cnt=0, all strobes 0.
  - The following 4 samples give out_valid=0.
